// File: rtl/mash_sdm.sv
// MASH 1-1-1 sigma-delta modulator with run-time order select (1..3),
// optional LFSR dither at the stage-1 LSB, and a registered multi-bit
// noise-cancelled divider offset.
module mash_sdm #(
    parameter int W      = 24,
    parameter int OUT_W  = 4,
    parameter int LFSR_W = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [W-1:0]     frac,
    input  logic [1:0]       order,
    input  logic             dither_en,
    output logic [OUT_W-1:0] div_off,
    output logic [W-1:0]     qe,
    output logic             lfsr_bit
);

    // Zero-extend a single carry into the output width; the network is then
    // evaluated in modulo-2^OUT_W arithmetic, which yields the two's-complement result.
    function automatic logic [OUT_W-1:0] ext1(input logic b);
        return {{(OUT_W-1){1'b0}}, b};
    endfunction

    logic [W-1:0]      acc1_q, acc2_q, acc3_q;
    logic              c2_d1_q, c3_d1_q, c3_d2_q;
    logic [OUT_W-1:0]  div_off_q;
    logic [W-1:0]      qe_q;
    logic [LFSR_W-1:0] lfsr_q;

    logic [1:0]        ord_eff;
    logic              stage2_on, stage3_on;
    logic              dith;
    logic [W-1:0]      in1;
    logic [W:0]        sum1_d, sum2_d, sum3_d;
    logic              c1, c2, c3;
    logic [OUT_W-1:0]  y_d;
    logic              lfsr_fb;
    logic [LFSR_W-1:0] lfsr_d;

    // Combinational accumulator chain, stage gating and noise cancellation
    always_comb begin
        ord_eff   = (order == 2'd0) ? 2'd1 : order;
        stage2_on = (ord_eff >= 2'd2);
        stage3_on = (ord_eff == 2'd3);

        // Dither bit is the current LFSR output, applied before it advances
        dith = dither_en & lfsr_q[LFSR_W-1];
        in1  = frac + {{(W-1){1'b0}}, dith};

        sum1_d = {1'b0, acc1_q} + {1'b0, in1};
        sum2_d = '0;
        sum3_d = '0;
        if (stage2_on) begin
            sum2_d = {1'b0, acc2_q} + {1'b0, sum1_d[W-1:0]};
        end
        if (stage3_on) begin
            sum3_d = {1'b0, acc3_q} + {1'b0, sum2_d[W-1:0]};
        end

        c1 = sum1_d[W];
        c2 = sum2_d[W];
        c3 = sum3_d[W];

        // y = c1 + (c2 - c2_d1) + (c3 - 2*c3_d1 + c3_d2)
        y_d = ext1(c1)
            + ext1(c2) - ext1(c2_d1_q)
            + ext1(c3) - (ext1(c3_d1_q) << 1) + ext1(c3_d2_q);

        // Fibonacci LFSR for x^LFSR_W + x^(LFSR_W-1) + 1
        lfsr_fb = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2];
        lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_fb};
    end

    // State update on enabled edges; disabled stages are held at zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc1_q    <= '0;
            acc2_q    <= '0;
            acc3_q    <= '0;
            c2_d1_q   <= 1'b0;
            c3_d1_q   <= 1'b0;
            c3_d2_q   <= 1'b0;
            div_off_q <= '0;
            qe_q      <= '0;
            lfsr_q    <= {{(LFSR_W-1){1'b0}}, 1'b1};
        end else if (en) begin
            acc1_q    <= sum1_d[W-1:0];
            acc2_q    <= sum2_d[W-1:0];
            acc3_q    <= sum3_d[W-1:0];
            c2_d1_q   <= c2;
            c3_d1_q   <= c3;
            c3_d2_q   <= stage3_on ? c3_d1_q : 1'b0;
            div_off_q <= y_d;
            qe_q      <= sum1_d[W-1:0];
            lfsr_q    <= lfsr_d;
        end
    end

    assign div_off  = div_off_q;
    assign qe       = qe_q;
    assign lfsr_bit = lfsr_q[LFSR_W-1];

endmodule
